float_act_pipe: RTL and testbench
=================================

Name: float_act_pipe

Overview:
- Streaming, multi-lane floating-point activation unit; successor to the single-word combinational ReLU.
- Applies a per-transfer selectable activation to LANES packed IEEE-style floats: pass, ReLU, leaky ReLU (power-of-two slope), or clamped ReLU.
- Two-stage registered pipeline with valid/ready handshakes on both sides.
- Sits between the matmul result path and the next layer's input buffer.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- FRAC_WIDTH, 23, fraction field width; word width W = 1 + EXP_WIDTH + FRAC_WIDTH.
- LANES, 4, floats per transfer.
- CNT_WIDTH, 32, width of the transfer counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transfer valid.
- in_ready  out  1  unit can accept an input transfer.
- in_data  in  LANES*W  lane i at bits [i*W +: W].
- in_mode  in  2  0=pass, 1=ReLU, 2=leaky, 3=clamp; sampled with the data.
- leak_shift  in  EXP_WIDTH  leaky slope 2^-leak_shift; quasi-static.
- clamp_max  in  W  positive clamp bound; quasi-static, sign bit ignored.
- out_valid  out  1  output transfer valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*W  results, same lane packing.
- out_count  out  CNT_WIDTH  number of completed output transfers; wraps.

Behaviour:
- Reset is asynchronous and active-high on rst; clocked by clk. While rst is high: all stage valids = 0, out_valid = 0, out_data = 0, out_count = 0. in_ready = 1 from the first cycle after reset is released.
- A transfer occurs when valid && ready on a clk rising edge.
- Stage S1 registers in_data and in_mode. Stage S2 registers the computed results. Latency: 2 clk from input acceptance to out_valid, with out_ready held high. Throughput: 1 transfer/cycle.
- Stall rules: S2 loads when !s2_valid || out_ready. S1 advances when S2 loads. in_ready = !s1_valid || (S2 loads). Purely combinational ready chain; no skid buffer.
- Held data is frozen while out_valid && !out_ready. out_data must not change until accepted.
- Per lane, with fields s, e, f:
  - pass: out = in, bit-exact.
  - ReLU: s=1 -> +0 (covers -0, -inf, -NaN); else out = in.
  - leaky, s=0: out = in.
  - leaky, s=1, e = all-ones (inf/NaN): out = in.
  - leaky, s=1, e > leak_shift: out = {1, e - leak_shift, f}.
  - leaky, s=1, e <= leak_shift (incl. subnormals and -0): out = +0. Flush-to-zero, no denormalisation.
  - leak_shift = 0: leaky behaves as pass for negatives with e > 0.
  - clamp: s=1 -> +0. Otherwise compare {e,f} against clamp_max[W-2:0] as unsigned. If greater, out = {0, clamp_max[W-2:0]}; else out = in. +inf and +NaN therefore clamp to the bound.
- Lanes are independent; a transfer's mode applies to all lanes.
- out_count increments by 1 on each out_valid && out_ready. It wraps from 2^CNT_WIDTH-1 to 0.
- Simultaneous accept-in and emit-out with both stages full: sustained, no bubble.
- rst asserted mid-stream: in-flight transfers are discarded and never emitted; out_count returns to 0.

Decomposition:
- Shared package/header: W derivation, field-slice helpers (sign/exp/frac), and the mode encodings (MODE_PASS=0, MODE_RELU=1, MODE_LEAKY=2, MODE_CLAMP=3).
- One sub-module, float_act_lane: a purely combinational single-float activation (mode, leak_shift, clamp_max -> result). It is instantiated LANES times by a generate loop between S1 and S2.

Test Plan (EXP=8, FRAC=23, LANES=4):
- Reset/latency: rst high mid-stream, then release; present one transfer with out_ready=1 -> out_valid rises exactly 2 cycles after acceptance; out_count=1. Reset discards any pending transfer.
- ReLU lanes {0xC0000000 (-2.0), 0x3F800000, 0x80000000, 0xFFC00000} -> {0, 0x3F800000, 0, 0}.
- Leaky with leak_shift=3, lanes {0xC0000000, 0x80800000, 0xFF800000, 0x40400000} -> {0xBE800000 (-0.25), 0, 0xFF800000, 0x40400000}.
- Clamp with clamp_max=0x40C00000 (6.0), lanes {0x40E00000 (7.0), 0x40A00000, 0x7F800000, 0xBF800000} -> {0x40C00000, 0x40A00000, 0x40C00000, 0}.
- Backpressure: 10 back-to-back transfers with out_ready toggled randomly -> all 10 emitted in order, unchanged while stalled, none dropped or duplicated; out_count=10.
- Counter wrap (CNT_WIDTH=4): 17 transfers -> out_count=1; mixed modes per transfer, each output matches its own sampled mode.

Source files
------------

// File: rtl/float_act_pipe_pkg.sv
// rtl/float_act_pipe_pkg.sv - shared mode encodings and word-width helper for the activation pipe
package float_act_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_RELU  = 2'd1,
        MODE_LEAKY = 2'd2,
        MODE_CLAMP = 2'd3
    } act_mode_t;

    function automatic int word_width(input int exp_width, input int frac_width);
        return 1 + exp_width + frac_width;
    endfunction

endpackage

// File: rtl/float_act_lane.sv
// rtl/float_act_lane.sv - combinational single-float activation (pass/relu/leaky/clamp)
module float_act_lane
    import float_act_pipe_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23,
    parameter int W          = word_width(EXP_WIDTH, FRAC_WIDTH)
) (
    input  logic [W-1:0]         din,
    input  act_mode_t            mode,
    input  logic [EXP_WIDTH-1:0] leak_shift,
    input  logic [W-1:0]         clamp_max,
    output logic [W-1:0]         dout
);

    logic                  s;
    logic [EXP_WIDTH-1:0]  e;
    logic [FRAC_WIDTH-1:0] f;
    logic [W-1:0]          mag;
    logic [W-1:0]          bound;

    assign s     = din[W-1];
    assign e     = din[W-2 -: EXP_WIDTH];
    assign f     = din[FRAC_WIDTH-1:0];
    assign mag   = {1'b0, din[W-2:0]};
    // Sign of the bound is ignored, so the bound is always a non-negative value.
    assign bound = clamp_max & {1'b0, {(W-1){1'b1}}};

    always_comb begin
        dout = din;
        case (mode)
            MODE_PASS: dout = din;
            MODE_RELU: dout = s ? '0 : din;
            MODE_LEAKY: begin
                // Negative results that would underflow are flushed to +0.
                if (!s || (&e))
                    dout = din;
                else if (e > leak_shift)
                    dout = {1'b1, e - leak_shift, f};
                else
                    dout = '0;
            end
            MODE_CLAMP: begin
                if (s)
                    dout = '0;
                else if (mag > bound)
                    dout = bound;
                else
                    dout = din;
            end
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/float_act_pipe.sv
// rtl/float_act_pipe.sv - two-stage streaming multi-lane float activation unit
module float_act_pipe
    import float_act_pipe_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23,
    parameter int LANES      = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int W          = word_width(EXP_WIDTH, FRAC_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   in_data,
    input  logic [1:0]           in_mode,
    input  logic [EXP_WIDTH-1:0] leak_shift,
    input  logic [W-1:0]         clamp_max,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_data,
    output logic [CNT_WIDTH-1:0] out_count
);

    logic               s1_valid;
    logic [LANES*W-1:0] s1_data;
    act_mode_t          s1_mode;
    logic               s2_valid;
    logic [LANES*W-1:0] s2_data;
    logic [LANES*W-1:0] lane_result;
    logic               s2_load;

    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign out_valid = s2_valid;
    assign out_data  = s2_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= MODE_PASS;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_mode <= act_mode_t'(in_mode);
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        float_act_lane #(
            .EXP_WIDTH  (EXP_WIDTH),
            .FRAC_WIDTH (FRAC_WIDTH),
            .W          (W)
        ) u_lane (
            .din        (s1_data[i*W +: W]),
            .mode       (s1_mode),
            .leak_shift (leak_shift),
            .clamp_max  (clamp_max),
            .dout       (lane_result[i*W +: W])
        );
    end

    // Output register only changes when empty or being drained, so stalled data holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid)
                s2_data <= lane_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_count <= '0;
        else if (s2_valid && out_ready)
            out_count <= out_count + 1'b1;
    end

endmodule

// File: tb/tb_float_act_pipe.sv
// tb/tb_float_act_pipe.sv - scoreboard bench for float_act_pipe against a field-level reference model
module tb_float_act_pipe;

    localparam int LANES = 4;
    localparam int CW    = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [127:0]       in_data;
    logic [1:0]         in_mode;
    logic [7:0]         leak_shift;
    logic [31:0]        clamp_max;
    logic               out_valid;
    logic               out_ready;
    logic [127:0]       out_data;
    logic [CW-1:0]      out_count;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];
    int   exp_cnt = 0;
    logic prev_stall = 1'b0;
    logic [127:0] prev_data = '0;
    logic rand_rdy = 1'b0;

    float_act_pipe #(
        .EXP_WIDTH (8),
        .FRAC_WIDTH(23),
        .LANES     (LANES),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .leak_shift(leak_shift),
        .clamp_max (clamp_max),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_lane(input logic [31:0] x, input int mode,
                                             input int ls, input logic [31:0] cm);
        int exponent = int'(x[30:23]);
        logic [31:0] r;
        r = x;
        if (mode == 1 && x[31]) r = 32'h0;
        if (mode == 2 && x[31] && exponent != 255) begin
            if (exponent - ls >= 1) r = {1'b1, 8'(exponent - ls), x[22:0]};
            else r = 32'h0;
        end
        if (mode == 3) begin
            if (x[31]) r = 32'h0;
            else if (x[30:0] > cm[30:0]) r = {1'b0, cm[30:0]};
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_xfer(input logic [127:0] d, input int mode);
        logic [127:0] r;
        for (int i = 0; i < LANES; i++)
            r[i*32 +: 32] = ref_lane(d[i*32 +: 32], mode, int'(leak_shift), clamp_max);
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: stall stability, output scoreboard and transfer counter model.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_cnt = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 128'(out_valid), 128'(1));
                check("stall_hold", out_data, prev_data);
            end
            check("out_count", 128'(out_count), 128'(exp_cnt % (1 << CW)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%h required=none", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
                exp_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [127:0] d, input logic [1:0] m,
                        input logic use_exp, input logic [127:0] e);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end else begin
            exp_q.push_back(use_exp ? e : ref_xfer(d, int'(m)));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_out_count", 128'(out_count), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 128'(in_ready), 128'(1));
    endtask

    function automatic logic [31:0] rand_float();
        case ($urandom_range(0, 7))
            0: return 32'h8000_0000;
            1: return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom)};
            2: return {1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)), 23'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        int lat;
        bit seen;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 2'd0;
        out_ready = 1'b1; leak_shift = 8'd3; clamp_max = 32'h40C0_0000;
        do_reset();

        // Pending transfers must be discarded by a mid-stream reset.
        out_ready = 1'b0;
        send({4{32'h3F80_0000}}, 2'd0, 1'b0, '0);
        send({4{32'h4000_0000}}, 2'd0, 1'b0, '0);
        do_reset();
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Latency: out_valid visible two cycles after the accepting cycle.
        in_valid = 1'b1; in_data = {4{32'h4040_0000}}; in_mode = 2'd0;
        @(negedge clk);
        exp_q.push_back(in_data);
        @(posedge clk); #1; in_valid = 1'b0;
        lat = 0; seen = 0;
        for (int t = 1; t <= 10 && !seen; t++) begin
            @(negedge clk);
            if (out_valid) begin lat = t; seen = 1; end
        end
        check("latency", 128'(lat), 128'(2));
        drain();
        check("count_after_one", 128'(out_count), 128'(1));

        send({32'hFFC0_0000, 32'h8000_0000, 32'h3F80_0000, 32'hC000_0000}, 2'd1, 1'b1,
             {32'h0, 32'h0, 32'h3F80_0000, 32'h0});
        send({32'h4040_0000, 32'hFF80_0000, 32'h8080_0000, 32'hC000_0000}, 2'd2, 1'b1,
             {32'h4040_0000, 32'hFF80_0000, 32'h0, 32'hBE80_0000});
        send({32'hBF80_0000, 32'h7F80_0000, 32'h40A0_0000, 32'h40E0_0000}, 2'd3, 1'b1,
             {32'h0, 32'h40C0_0000, 32'h40A0_0000, 32'h40C0_0000});
        drain();

        // Backpressure: 10 transfers with random out_ready.
        do_reset();
        rand_rdy = 1'b1;
        for (int n = 0; n < 10; n++) begin
            for (int l = 0; l < LANES; l++) d[l*32 +: 32] = rand_float();
            send(d, 2'($urandom_range(0, 3)), 1'b0, '0);
        end
        drain();
        check("count_backpressure", 128'(out_count), 128'(10));

        // Counter wrap with mixed modes and varied slope/bound.
        do_reset();
        leak_shift = 8'($urandom_range(0, 10));
        clamp_max  = $urandom;
        for (int n = 0; n < 17; n++) begin
            for (int l = 0; l < LANES; l++) d[l*32 +: 32] = rand_float();
            send(d, 2'($urandom_range(0, 3)), 1'b0, '0);
        end
        drain();
        check("count_wrap", 128'(out_count), 128'(1));

        leak_shift = 8'd0;
        send({32'h8000_0001, 32'hC000_0000, 32'hFF80_0000, 32'h0040_0000}, 2'd2, 1'b1,
             {32'h0, 32'hC000_0000, 32'hFF80_0000, 32'h0040_0000});
        drain();

        check("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
